// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: tear-free shadow value, one digit enabled per slot.
// Optional inter-slot blanking is compiled in with `define SEG_SCAN_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned CLK_DIV      = 1200,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    pending,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || CLK_DIV < 2 || BLANK_CYCLES < 1) begin : g_bad_params
      $error("seg_scan_ctrl: parameter out of range");
    end
  endgenerate

  logic [DIV_W-1:0]        div_cnt_q,   div_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] buf_q,       buf_d;
  logic [4*NUM_DIGITS-1:0] shadow_q,    shadow_d;
  logic                    pending_q,   pending_d;
  logic [3:0]              nibble_q,    nibble_d;
  logic [NUM_DIGITS-1:0]   en_n_q,      en_n_d;
  logic                    frame_q,     frame_d;

  logic scanning;
  logic slot_end;
  logic advance;
  logic wrap;

`ifdef SEG_SCAN_BLANK_EN
  localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
`endif

  always_comb begin
    div_cnt_d   = div_cnt_q;
    digit_idx_d = digit_idx_q;
    buf_d       = buf_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    nibble_d    = nibble_q;
    en_n_d      = '1;
    frame_d     = 1'b0;
    advance     = 1'b0;
    wrap        = 1'b0;
    slot_end    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
`ifdef SEG_SCAN_BLANK_EN
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    scanning    = (state_q == SCAN);
`else
    scanning    = 1'b1;
`endif

    // Output registers capture the slot the current state describes, so they
    // trail the counters by one cycle; shadow_q here is the pre-commit copy.
    if (scanning) begin
      en_n_d[digit_idx_q] = 1'b0;
      nibble_d            = shadow_q[4*digit_idx_q +: 4];
      frame_d             = (digit_idx_q == '0) && (div_cnt_q == '0);
      if (slot_end) begin
        div_cnt_d = '0;
`ifdef SEG_SCAN_BLANK_EN
        state_d     = BLANK;
        blank_cnt_d = '0;
`else
        advance     = 1'b1;
`endif
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

`ifdef SEG_SCAN_BLANK_EN
    if (state_q == BLANK) begin
      if (blank_cnt_q == BLK_W'(BLANK_CYCLES - 1)) begin
        blank_cnt_d = '0;
        state_d     = SCAN;
        advance     = 1'b1;
      end else begin
        blank_cnt_d = blank_cnt_q + 1'b1;
      end
    end
`endif

    if (advance) begin
      if (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        digit_idx_d = '0;
        wrap        = 1'b1;
      end else begin
        digit_idx_d = digit_idx_q + 1'b1;
      end
    end

    // Commit reads the old buffer; a same-cycle load refills it and stays pending.
    if (wrap && pending_q) begin
      shadow_d  = buf_q;
      pending_d = 1'b0;
    end
    if (load) begin
      buf_d     = value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      buf_q       <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      nibble_q    <= '0;
      en_n_q      <= '1;
      frame_q     <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
      state_q     <= SCAN;
      blank_cnt_q <= '0;
`endif
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      buf_q       <= buf_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      nibble_q    <= nibble_d;
      en_n_q      <= en_n_d;
      frame_q     <= frame_d;
`ifdef SEG_SCAN_BLANK_EN
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
`endif
    end
  end

  assign pending    = pending_q;
  assign nibble_out = nibble_q;
  assign digit_en_n = en_n_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: timeline/frame reference model feeds an expected queue.
module tb_seg_scan_ctrl;

  localparam int ND   = 2;
  localparam int DIV  = 4;
  localparam int BLKP = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BLK  = BLKP;
`else
  localparam int BLK  = 0;
`endif
  localparam int P = DIV + BLK;
  localparam int F = ND * P;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [4*ND-1:0] value;
  logic            pending;
  logic [3:0]      nibble_out;
  logic [ND-1:0]   digit_en_n;
  logic            frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLKP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .pending   (pending),
    .nibble_out(nibble_out),
    .digit_en_n(digit_en_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] en;
    logic [3:0]    nib;
    logic          ft;
    logic          pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: display time t since reset, commits at frame boundaries.
  int            m_t = 0;
  logic [4*ND-1:0] m_buf = '0, m_shadow = '0;
  logic          m_pend = 1'b0;
  logic [3:0]    m_last = '0;

  always @(posedge clk) begin
    exp_t e;
    int   slot, phase;
    if (rst) begin
      m_t = 0; m_buf = '0; m_shadow = '0; m_pend = 1'b0; m_last = '0;
      e.en = '1; e.nib = '0; e.ft = 1'b0; e.pend = 1'b0;
    end else begin
      phase = m_t % P;
      slot  = (m_t / P) % ND;
      e.en  = '1;
      if (phase < DIV) begin
        e.en[slot] = 1'b0;
        m_last     = m_shadow[4*slot +: 4];
      end
      e.nib = m_last;
      e.ft  = ((m_t % F) == 0);
      m_t++;
      if ((m_t % F) == 0 && m_pend) begin
        m_shadow = m_buf;
        m_pend   = 1'b0;
      end
      if (load) begin
        m_buf  = value;
        m_pend = 1'b1;
      end
      e.pend = m_pend;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (digit_en_n !== e.en) begin
        errors++;
        $display("FAIL digit_en_n at %0t: got %b expected %b", $time, digit_en_n, e.en);
      end
      checks++;
      if (nibble_out !== e.nib) begin
        errors++;
        $display("FAIL nibble_out at %0t: got %h expected %h", $time, nibble_out, e.nib);
      end
      checks++;
      if (frame_tick !== e.ft) begin
        errors++;
        $display("FAIL frame_tick at %0t: got %b expected %b", $time, frame_tick, e.ft);
      end
      checks++;
      if (pending !== e.pend) begin
        errors++;
        $display("FAIL pending at %0t: got %b expected %b", $time, pending, e.pend);
      end
      checks++;
      if ($countones(~digit_en_n) > 1) begin
        errors++;
        $display("FAIL one_digit at %0t: got %b expected at most one low", $time, digit_en_n);
      end
    end
  end

  task automatic step(input logic l, input logic [4*ND-1:0] v, input logic r);
    @(negedge clk);
    load  = l;
    value = v;
    rst   = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  // Advance until the next posedge is the frame-commit edge; then load v there.
  task automatic load_at_commit(input logic [4*ND-1:0] v);
    bit hit = 1'b0;
    for (int i = 0; i < 4 * F && !hit; i++) begin
      @(negedge clk);
      rst = 1'b0;
      if (((m_t + 1) % F) == 0) begin
        load = 1'b1; value = v; hit = 1'b1;
      end else begin
        load = 1'b0; value = 8'($urandom);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL commit_align: got no commit edge expected one within %0d cycles", 4 * F);
    end
  endtask

  task automatic wait_digit1();
    bit hit = 1'b0;
    for (int i = 0; i < 4 * F && !hit; i++) begin
      if (((m_t / P) % ND) == 1 && (m_t % P) < DIV - 1) hit = 1'b1;
      else step(1'b0, 8'($urandom), 1'b0);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL digit1_wait: got no digit-1 slot expected one within %0d cycles", 4 * F);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    idle(3 * F);

    step(1'b1, 8'hA5, 1'b0);
    idle(3 * F);

    idle(1);
    step(1'b1, 8'h12, 1'b0);
    idle(1);
    step(1'b1, 8'h34, 1'b0);
    idle(2 * F + 3);

    step(1'b1, 8'h12, 1'b0);
    load_at_commit(8'h77);
    idle(3 * F);

    step(1'b1, 8'h3C, 1'b0);
    wait_digit1();
    step(1'b0, 8'hFF, 1'b1);
    idle(3 * F);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 150) == 0));
    end
    idle(2 * F);
    load = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
